// File: rtl/snoop_bus_pkg.sv
// Shared definitions for the snooping-bus arbiter and the per-line MSI coherence FSMs.
package snoop_bus_pkg;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_RDMISS = 2'b01;
  localparam logic [1:0] OP_WRMISS = 2'b10;
  localparam logic [1:0] OP_INV    = 2'b11;

  localparam logic [1:0] MSI_INVALID  = 2'b00;
  localparam logic [1:0] MSI_SHARED   = 2'b01;
  localparam logic [1:0] MSI_MODIFIED = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BCAST,
    ST_SNOOP,
    ST_WB,
    ST_MEM,
    ST_DONE
  } busState_t;

  // Index of the set bit in a one-hot vector of up to 8 requesters.
  function automatic logic [2:0] ohToIdx(input logic [7:0] oneHot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oneHot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after the pointer, as a one-hot grant.
module rr_arbiter #(
  parameter int NUM_CPU = 4,
  parameter int PTR_W   = $clog2(NUM_CPU)
) (
  input  logic [NUM_CPU-1:0] req,
  input  logic [PTR_W-1:0]   pointer,
  output logic [NUM_CPU-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CPU; i++) begin
      idx = (int'(pointer) + i) % NUM_CPU;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus arbiter/sequencer: grant, broadcast, collect snoop responses, writeback, memory read, complete.
// States: IDLE arbitrate | BCAST broadcast | SNOOP sample responses | WB writeback | MEM read | DONE complete.
module snoop_bus_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int NUM_CPU = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CPU-1:0]        req,
  input  logic [2*NUM_CPU-1:0]      req_op,
  input  logic [ADDR_W*NUM_CPU-1:0] req_addr,
  output logic                      bus_valid,
  output logic [1:0]                bus_op,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [NUM_CPU-1:0]        bus_src,
  input  logic [NUM_CPU-1:0]        snoop_wb,
  input  logic [NUM_CPU-1:0]        snoop_abort,
  input  logic [DATA_W*NUM_CPU-1:0] snoop_data,
  output logic                      mem_wr,
  output logic                      mem_rd,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [NUM_CPU-1:0]        done,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      protocol_error
);

  localparam int PTR_W = $clog2(NUM_CPU);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  busState_t          state;
  logic [PTR_W-1:0]   pointer;
  logic [NUM_CPU-1:0] src;
  logic [1:0]         op;
  logic [ADDR_W-1:0]  addr;
  logic               wbAbort;
  logic [CNT_W-1:0]   memCnt;

  logic [NUM_CPU-1:0] eligible;
  logic [NUM_CPU-1:0] grant;
  logic [NUM_CPU-1:0] wbMasked;
  logic [1:0]         grantOp;
  logic [ADDR_W-1:0]  grantAddr;
  logic               wbMulti;
  int                 gIdx;
  int                 wbIdx;
  int                 srcIdx;

  rr_arbiter #(.NUM_CPU(NUM_CPU), .PTR_W(PTR_W)) u_rrArbiter (
    .req     (eligible),
    .pointer (pointer),
    .grant   (grant)
  );

  // The requester's own writeback bit never counts as a snoop response.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      eligible[i] = req[i] && (req_op[2*i +: 2] != OP_NONE);
    end
    gIdx      = int'(ohToIdx(8'(grant)));
    grantOp   = req_op[2*gIdx +: 2];
    grantAddr = req_addr[ADDR_W*gIdx +: ADDR_W];
    wbMasked  = snoop_wb & ~src;
    wbIdx     = int'(ohToIdx(8'(wbMasked & (~wbMasked + NUM_CPU'(1)))));
    wbMulti   = |(wbMasked & (wbMasked - NUM_CPU'(1)));
    srcIdx    = int'(ohToIdx(8'(src)));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      pointer        <= '0;
      src            <= '0;
      op             <= OP_NONE;
      addr           <= '0;
      wbAbort        <= 1'b0;
      memCnt         <= '0;
      bus_valid      <= 1'b0;
      bus_op         <= OP_NONE;
      bus_addr       <= '0;
      bus_src        <= '0;
      mem_wr         <= 1'b0;
      mem_rd         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      done           <= '0;
      resp_data      <= '0;
      protocol_error <= 1'b0;
    end else begin
      bus_valid <= 1'b0;
      mem_wr    <= 1'b0;
      done      <= '0;
      case (state)
        ST_IDLE: begin
          if (|eligible) begin
            src       <= grant;
            op        <= grantOp;
            addr      <= grantAddr;
            bus_valid <= 1'b1;
            bus_op    <= grantOp;
            bus_addr  <= grantAddr;
            bus_src   <= grant;
            state     <= ST_BCAST;
          end
        end
        ST_BCAST: state <= ST_SNOOP;
        ST_SNOOP: begin
          if (wbMulti) protocol_error <= 1'b1;
          if (|wbMasked) begin
            wbAbort   <= snoop_abort[wbIdx];
            mem_wr    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= snoop_data[DATA_W*wbIdx +: DATA_W];
            state     <= ST_WB;
          end else if (op == OP_INV) begin
            done      <= src;
            resp_data <= '0;
            state     <= ST_DONE;
          end else begin
            mem_rd   <= 1'b1;
            mem_addr <= addr;
            memCnt   <= CNT_W'(MEM_LAT - 1);
            state    <= ST_MEM;
          end
        end
        ST_WB: begin
          if (op == OP_INV) begin
            done      <= src;
            resp_data <= '0;
            state     <= ST_DONE;
          end else if (wbAbort) begin
            done      <= src;
            resp_data <= mem_wdata;
            state     <= ST_DONE;
          end else begin
            mem_rd <= 1'b1;
            memCnt <= CNT_W'(MEM_LAT - 1);
            state  <= ST_MEM;
          end
        end
        ST_MEM: begin
          if (memCnt == '0) begin
            mem_rd    <= 1'b0;
            resp_data <= mem_rdata;
            done      <= src;
            state     <= ST_DONE;
          end else begin
            memCnt <= memCnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          pointer <= PTR_W'((srcIdx + 1) % NUM_CPU);
          bus_src <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences, randomized rounds vs. a transaction model.
module tb_snoop_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int L  = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [2*N-1:0]  req_op = '0;
  logic [AW*N-1:0] req_addr = '0;
  logic            bus_valid;
  logic [1:0]      bus_op;
  logic [AW-1:0]   bus_addr;
  logic [N-1:0]    bus_src;
  logic [N-1:0]    snoop_wb = '0;
  logic [N-1:0]    snoop_abort = '0;
  logic [DW*N-1:0] snoop_data = '0;
  logic            mem_wr;
  logic            mem_rd;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;
  logic [N-1:0]    done;
  logic [DW-1:0]   resp_data;
  logic            protocol_error;

  always #5 clock = ~clock;

  snoop_bus_arbiter #(.NUM_CPU(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) dut (
    .clock(clock), .reset(reset), .req(req), .req_op(req_op), .req_addr(req_addr),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .bus_src(bus_src),
    .snoop_wb(snoop_wb), .snoop_abort(snoop_abort), .snoop_data(snoop_data),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .done(done), .resp_data(resp_data), .protocol_error(protocol_error)
  );

  typedef struct {
    int            cpu;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [N-1:0]  wb;
    logic [N-1:0]  ab;
    logic [DW*N-1:0] sdata;
    logic [DW-1:0] rdata;
  } txn_t;

  typedef struct {
    int            lat;
    logic [N-1:0]  doneV;
    logic [DW-1:0] resp;
    int            wrCnt;
    logic [DW-1:0] wdata;
    int            rdCnt;
    logic          perr;
  } res_t;

  typedef struct {
    txn_t t;
    res_t e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   modelPtr = 0;
  logic modelPerr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outcome of one transaction, from the bus protocol rules.
  function automatic res_t model(input txn_t t, input logic perrIn);
    res_t r;
    logic [N-1:0] wbE;
    int sel;
    int cnt;
    wbE = t.wb & ~(N'(1) << t.cpu);
    r.doneV = N'(1) << t.cpu;
    r.perr = perrIn;
    r.wrCnt = 0;
    r.rdCnt = 0;
    r.wdata = '0;
    r.resp = '0;
    r.lat = 0;
    sel = -1;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (wbE[i]) begin
        cnt++;
        if (sel < 0) sel = i;
      end
    end
    if (cnt > 1) r.perr = 1'b1;
    if (sel >= 0) begin
      r.wrCnt = 1;
      r.wdata = t.sdata[DW*sel +: DW];
      if (t.op == 2'b11) r.lat = 4;
      else if (t.ab[sel]) begin
        r.lat = 4;
        r.resp = r.wdata;
      end else begin
        r.lat = 4 + L;
        r.rdCnt = L;
        r.resp = t.rdata;
      end
    end else if (t.op == 2'b11) begin
      r.lat = 3;
    end else begin
      r.lat = 3 + L;
      r.rdCnt = L;
      r.resp = t.rdata;
    end
    return r;
  endfunction

  function automatic int expGrant();
    for (int i = 0; i < N; i++) begin
      int c;
      c = (modelPtr + i) % N;
      if (req[c] && req_op[2*c +: 2] != 2'b00) return c;
    end
    return -1;
  endfunction

  task automatic setReq(input int cpu, input logic [1:0] op, input logic [AW-1:0] addr);
    req_op[2*cpu +: 2] = op;
    req_addr[AW*cpu +: AW] = addr;
    req[cpu] = 1'b1;
  endtask

  // Waits for the broadcast, plays the snoop responses, and records what the bus and memory did.
  task automatic doTxn(input txn_t t, input bit keep, output res_t o);
    int k;
    bit seen;
    int addrBad;
    int bvExtra;
    o.lat = -1; o.doneV = '0; o.resp = '0; o.wrCnt = 0; o.wdata = '0; o.rdCnt = 0; o.perr = 1'b0;
    snoop_wb = '0; snoop_abort = '0; snoop_data = '0;
    mem_rdata = t.rdata;
    seen = 0;
    addrBad = 0;
    bvExtra = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clock); #1;
      if (bus_valid) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL grant_timeout: no bus_valid for cpu %0d", t.cpu);
      return;
    end
    check("bus_src", bus_src, N'(1) << t.cpu);
    check("bus_op", bus_op, t.op);
    check("bus_addr", bus_addr, t.addr);
    k = 1;
    while (k < 16 && o.lat < 0) begin
      @(posedge clock); #1;
      k++;
      if (k == 2) begin
        snoop_wb = t.wb; snoop_abort = t.ab; snoop_data = t.sdata;
      end
      if (bus_valid) bvExtra++;
      if (mem_rd) begin
        o.rdCnt++;
        if (mem_addr !== t.addr) addrBad++;
      end
      if (mem_wr) begin
        o.wrCnt++;
        o.wdata = mem_wdata;
        if (mem_addr !== t.addr) addrBad++;
      end
      if (done != '0) begin
        o.lat = k; o.doneV = done; o.resp = resp_data; o.perr = protocol_error;
      end
    end
    if (!keep) req[t.cpu] = 1'b0;
    snoop_wb = '0; snoop_abort = '0; snoop_data = '0;
    check("mem_addr_errs", 64'(addrBad), 0);
    check("bus_valid_extra", 64'(bvExtra), 0);
    @(posedge clock); #1;
    check("done_one_cycle", done, '0);
  endtask

  task automatic cmpRes(input string tag, input res_t o, input res_t e);
    check({tag, ".lat"}, 64'(o.lat), 64'(e.lat));
    check({tag, ".done"}, o.doneV, e.doneV);
    check({tag, ".resp"}, o.resp, e.resp);
    check({tag, ".wr_cnt"}, 64'(o.wrCnt), 64'(e.wrCnt));
    check({tag, ".wdata"}, o.wdata, e.wdata);
    check({tag, ".rd_cnt"}, 64'(o.rdCnt), 64'(e.rdCnt));
    check({tag, ".perr"}, o.perr, e.perr);
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, ".bus_valid"}, bus_valid, 0);
    check({tag, ".bus_src"}, bus_src, 0);
    check({tag, ".mem_wr"}, mem_wr, 0);
    check({tag, ".mem_rd"}, mem_rd, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".resp_data"}, resp_data, 0);
    check({tag, ".perr"}, protocol_error, 0);
  endtask

  vec_t vecs[7];
  int   order[5];

  initial begin
    res_t o;
    res_t e;
    txn_t t;

    vecs[0] = '{'{1, 2'b01, 5'd5,  4'b0000, 4'b0000, 32'h0000_0000, 8'h3C},
                '{5, 4'b0010, 8'h3C, 0, 8'h00, 2, 1'b0}};
    vecs[1] = '{'{0, 2'b10, 5'd3,  4'b0100, 4'b0100, 32'h00A5_0000, 8'h99},
                '{4, 4'b0001, 8'hA5, 1, 8'hA5, 0, 1'b0}};
    vecs[2] = '{'{3, 2'b11, 5'd7,  4'b1000, 4'b1000, 32'hEE00_0000, 8'h44},
                '{3, 4'b1000, 8'h00, 0, 8'h00, 0, 1'b0}};
    vecs[3] = '{'{2, 2'b01, 5'd9,  4'b0010, 4'b0000, 32'h0000_5A00, 8'h77},
                '{6, 4'b0100, 8'h77, 1, 8'h5A, 2, 1'b0}};
    vecs[4] = '{'{1, 2'b11, 5'h1F, 4'b0000, 4'b0000, 32'h0000_0000, 8'h12},
                '{3, 4'b0010, 8'h00, 0, 8'h00, 0, 1'b0}};
    vecs[5] = '{'{3, 2'b10, 5'h10, 4'b0101, 4'b0001, 32'h0022_0011, 8'h66},
                '{4, 4'b1000, 8'h11, 1, 8'h11, 0, 1'b1}};
    vecs[6] = '{'{0, 2'b01, 5'd2,  4'b0001, 4'b0000, 32'h0000_0000, 8'hC3},
                '{5, 4'b0001, 8'hC3, 0, 8'h00, 2, 1'b1}};
    order = '{0, 1, 2, 3, 0};

    repeat (2) @(posedge clock);
    #1;
    checkIdleOutputs("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    for (int v = 0; v < 7; v++) begin
      setReq(vecs[v].t.cpu, vecs[v].t.op, vecs[v].t.addr);
      doTxn(vecs[v].t, 1'b0, o);
      cmpRes($sformatf("vec%0d", v), o, vecs[v].e);
      modelPtr = (vecs[v].t.cpu + 1) % N;
      modelPerr = vecs[v].e.perr;
    end

    // Reset in the middle of the memory read phase.
    setReq(2, 2'b01, 5'd4);
    for (int c = 0; c < 20 && !mem_rd; c++) begin
      @(posedge clock); #1;
    end
    check("mid_reset.mem_rd_seen", mem_rd, 1);
    #2 reset = 1'b1;
    #1;
    req[2] = 1'b0;
    checkIdleOutputs("mid_reset");
    repeat (2) begin
      @(posedge clock); #1;
      check("mid_reset.no_done", done, 0);
    end
    reset = 1'b0;
    modelPtr = 0;
    modelPerr = 1'b0;
    @(posedge clock); #1;
    check("after_reset.no_done", done, 0);

    // All four request together; cpu0 keeps requesting through its first completion.
    setReq(0, 2'b01, 5'd0);
    setReq(1, 2'b10, 5'd1);
    setReq(2, 2'b11, 5'd2);
    setReq(3, 2'b01, 5'd3);
    for (int j = 0; j < 5; j++) begin
      t.cpu = order[j];
      t.op = req_op[2*order[j] +: 2];
      t.addr = req_addr[AW*order[j] +: AW];
      t.wb = '0; t.ab = '0; t.sdata = '0;
      t.rdata = 8'(8'h20 + j);
      doTxn(t, j == 0, o);
      e = model(t, modelPerr);
      modelPerr = e.perr;
      cmpRes($sformatf("rr%0d", j), o, e);
      modelPtr = (order[j] + 1) % N;
    end

    for (int r = 0; r < 40; r++) begin
      int c;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0) setReq(i, 2'($urandom_range(0, 3)), AW'($urandom));
      end
      c = expGrant();
      if (c < 0) begin
        repeat (3) @(posedge clock);
        #1;
        check("rand.no_grant", bus_src, 0);
      end
      while (c >= 0) begin
        t.cpu = c;
        t.op = req_op[2*c +: 2];
        t.addr = req_addr[AW*c +: AW];
        t.wb = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
        t.ab = N'($urandom);
        t.sdata = (DW*N)'($urandom);
        t.rdata = DW'($urandom);
        doTxn(t, 1'b0, o);
        e = model(t, modelPerr);
        modelPerr = e.perr;
        cmpRes($sformatf("rand%0d_cpu%0d", r, c), o, e);
        modelPtr = (c + 1) % N;
        c = expGrant();
      end
      req = '0;
      repeat (2) @(posedge clock);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Arbiter and transaction sequencer for the shared snooping bus that connects the per-line MSI coherence state machines of NUM_CPU caches to main memory. It grants the bus to one requesting cache at a time in round-robin order and broadcasts the miss or invalidate to every snooper. It then collects the snoopers' writeback/abort responses, runs the writeback and memory-read phases, and returns data to the requester with a completion pulse.

## Interface
- NUM_CPU, 4, number of cache requesters/snoopers (2..8)
- ADDR_W, 5, block address width
- DATA_W, 8, block data width
- MEM_LAT, 2, memory read latency in cycles (>=1)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_CPU  per-cache bus request; held until matching done
- req_op  in  2*NUM_CPU  per-cache op: 01 read miss, 10 write miss, 11 invalidate, 00 ignored
- req_addr  in  ADDR_W*NUM_CPU  per-cache block address
- bus_valid  out  1  one-cycle broadcast strobe
- bus_op  out  2  broadcast op
- bus_addr  out  ADDR_W  broadcast address
- bus_src  out  NUM_CPU  one-hot owner of current transaction
- snoop_wb  in  NUM_CPU  per-snooper writeBack response
- snoop_abort  in  NUM_CPU  per-snooper abortMemoryAccess response
- snoop_data  in  DATA_W*NUM_CPU  per-snooper writeback data
- mem_wr  out  1  memory write strobe (one cycle)
- mem_rd  out  1  memory read, held MEM_LAT cycles
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid on last mem_rd cycle
- done  out  NUM_CPU  one-hot completion pulse
- resp_data  out  DATA_W  fill data, valid with done
- protocol_error  out  1  sticky: >1 snooper asserted snoop_wb

## Operation
- FSM: IDLE, BCAST, SNOOP, WB, MEM, DONE.
- IDLE: if any req with nonzero op, the round-robin arbiter picks the first requester at or after pointer; latch src, op, addr; go BCAST. Requests with op 00 are not eligible.
- BCAST: bus_valid=1 with latched op/addr/src; go SNOOP.
- SNOOP: sample snoop_wb/snoop_abort, masking out the src bit. If any wb: select lowest-index asserting snooper, latch its data and abort flag, go WB. Otherwise: invalidate goes to DONE; miss goes to MEM.
- Multiple wb bits after masking set protocol_error; it clears only on reset.
- WB: mem_wr=1, mem_addr=addr, mem_wdata=latched snoop data. Next state is DONE if the op is invalidate or abort was latched (resp_data = snoop data); otherwise MEM.
- MEM: mem_rd=1 for MEM_LAT cycles via down-counter; capture mem_rdata into resp_data on last cycle; go DONE.
- DONE: done=src for one cycle; pointer = index(src)+1 mod NUM_CPU; go IDLE.
- req deassertion mid-transaction is ignored; the transaction completes.
- Invalidate resp_data = 0.

## Timing
- Reset: state IDLE, pointer 0; all outputs 0, including protocol_error and resp_data.
- Reset mid-transaction: immediate return to IDLE. No done is issued and in-flight mem_rd/mem_wr drop asynchronously.
- Moore outputs only, all registered or state-decoded.
- Snoopers respond on the edge after bus_valid; the response is sampled in SNOOP.
- Latency from the IDLE edge that grants to the done cycle:
  - invalidate, no wb: 3 cycles
  - miss, no wb: 3+MEM_LAT cycles
  - miss with wb+abort: 4 cycles
  - miss with wb, no abort: 4+MEM_LAT cycles
- Minimum one IDLE cycle between transactions.
- The requester owning done must drop or change req by the next edge; otherwise it is re-arbitrated normally.

## Structure
- Package snoop_bus_pkg holds:
  - op codes OP_NONE/OP_RDMISS/OP_WRMISS/OP_INV
  - FSM state enum
  - MSI state constants (00 invalid, 01 shared, 10 modified) shared with the per-line coherence FSMs
- Sub-module rr_arbiter: inputs req vector and pointer; outputs one-hot grant. Purely combinational.

## Test plan
- Reset then single read miss, cpu1, addr 5, no snoop response, MEM_LAT=2:
  - bus_valid with op 01, addr 5, src 0010
  - mem_rd for 2 cycles
  - done=0010 and resp_data=mem_rdata, 5 cycles after grant
- Write miss cpu0, addr 3; cpu2 responds wb=1, abort=1, data 0xA5:
  - mem_wr with wdata 0xA5, no mem_rd
  - done=0001 with resp_data 0xA5, 4 cycles after grant
- Invalidate from cpu3:
  - no memory strobes
  - done=1000 after 3 cycles
  - requester's own snoop_wb ignored and protocol_error stays 0
- All four request simultaneously:
  - grants in order 0,1,2,3, then 0 again if still requesting
  - pointer wraps correctly
- Two snoopers assert wb:
  - lowest index data written
  - protocol_error goes 1 and stays 1 until reset
- Reset asserted during MEM:
  - mem_rd drops immediately, no done issued
  - after release, a new request is granted starting from cpu0
